// File: rtl/gate_exerciser_pkg.sv
// rtl/gate_exerciser_pkg.sv - shared types and constants for the basic-gate exerciser
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int NUM_GATES   = 4;

    localparam int GATE_AND = 0;
    localparam int GATE_OR  = 1;
    localparam int GATE_XOR = 2;
    localparam int GATE_NOT = 3;

    localparam int         ERR_W   = 5;
    localparam logic [4:0] ERR_MAX = 5'd16;

    function automatic logic [2:0] popcount4(input logic [NUM_GATES-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/gate_exerciser_ref_model.sv
// rtl/gate_exerciser_ref_model.sv - combinational truth table for the and/or/xor/not gate set
module gate_ref_model
    import gate_exerciser_pkg::*;
(
    input  logic                 a,
    input  logic                 b,
    output logic [NUM_GATES-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[GATE_AND] = a & b;
        expected[GATE_OR]  = a | b;
        expected[GATE_XOR] = a ^ b;
        expected[GATE_NOT] = ~a;
    end

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - clocked stimulus/check sequencer driving A/B and scoring the gate outputs
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             A,
    output logic             B,
    input  logic             Y_and,
    input  logic             Y_or,
    input  logic             Y_xor,
    input  logic             Y_not,
    output logic [1:0]       vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_mask
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX  = 2'(NUM_VECTORS - 1);

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       hold, hold_nx;
    logic [1:0]             idx_nx, idx_inc;
    logic                   a_nx, b_nx, busy_nx, done_nx, pass_nx;
    logic [ERR_W-1:0]       err_nx, err_sat;
    logic [3:0]             mask_nx;
    logic [NUM_GATES-1:0]   expected, observed, mismatch;
    logic [ERR_W:0]         err_sum;
    logic                   check_edge;

    gate_ref_model u_ref (
        .a        (A),
        .b        (B),
        .expected (expected)
    );

    always_comb begin
        observed           = '0;
        observed[GATE_AND] = Y_and;
        observed[GATE_OR]  = Y_or;
        observed[GATE_XOR] = Y_xor;
        observed[GATE_NOT] = Y_not;
    end

    assign mismatch   = expected ^ observed;
    assign err_sum    = {1'b0, err_count} + {3'b000, popcount4(mismatch)};
    assign err_sat    = (err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_W-1:0];
    assign check_edge = (hold == HOLD_LAST);
    assign idx_inc    = vec_idx + 2'd1;

    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        idx_nx   = vec_idx;
        a_nx     = A;
        b_nx     = B;
        busy_nx  = busy;
        done_nx  = 1'b0;
        pass_nx  = pass;
        err_nx   = err_count;
        mask_nx  = fail_mask;

        case (state)
            IDLE: begin
                a_nx    = 1'b0;
                b_nx    = 1'b0;
                busy_nx = 1'b0;
                idx_nx  = 2'd0;
                hold_nx = '0;
                if (start) begin
                    state_nx = RUN;
                    busy_nx  = 1'b1;
                    err_nx   = '0;
                    mask_nx  = '0;
                    pass_nx  = 1'b0;
                end
            end
            RUN: begin
                if (!check_edge) begin
                    hold_nx = hold + 1'b1;
                end else begin
                    hold_nx = '0;
                    err_nx  = err_sat;
                    mask_nx = fail_mask | mismatch;
                    if (vec_idx == LAST_IDX) begin
                        state_nx = DONE;
                        idx_nx   = 2'd0;
                        a_nx     = 1'b0;
                        b_nx     = 1'b0;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        pass_nx  = (err_sat == '0);
                    end else begin
                        // Next vector goes out on the check edge itself so each is held exactly HOLD_CYCLES.
                        idx_nx = idx_inc;
                        a_nx   = idx_inc[1];
                        b_nx   = idx_inc[0];
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            vec_idx   <= 2'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_mask <= '0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            vec_idx   <= idx_nx;
            A         <= a_nx;
            B         <= b_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            err_count <= err_nx;
            fail_mask <= mask_nx;
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - randomized self-checking bench for gate_exerciser with fault-injected gates
module tb_gate_exerciser;

    localparam int H1 = 10;
    localparam int H2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start2;
    logic       a1, b1, ya1, yo1, yx1, yn1, busy1, done1, pass1;
    logic [1:0] idx1;
    logic [4:0] err1;
    logic [3:0] mask1;
    logic       a2, b2, ya2, yo2, yx2, yn2, busy2, done2, pass2;
    logic [1:0] idx2;
    logic [4:0] err2;
    logic [3:0] mask2;

    // Fault mode per gate: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 tied to A.
    int mode1[4];
    int mode2[4];

    int checks   = 0;
    int failures = 0;

    function automatic logic truth(input int g, input logic a, input logic b);
        case (g)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic obs(input int g, input int mode, input logic a, input logic b);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~truth(g, a, b);
            4:       return a;
            default: return truth(g, a, b);
        endcase
    endfunction

    always_comb begin
        ya1 = obs(0, mode1[0], a1, b1);
        yo1 = obs(1, mode1[1], a1, b1);
        yx1 = obs(2, mode1[2], a1, b1);
        yn1 = obs(3, mode1[3], a1, b1);
        ya2 = obs(0, mode2[0], a2, b2);
        yo2 = obs(1, mode2[1], a2, b2);
        yx2 = obs(2, mode2[2], a2, b2);
        yn2 = obs(3, mode2[3], a2, b2);
    end

    gate_exerciser #(.HOLD_CYCLES(H1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1),
        .Y_and(ya1), .Y_or(yo1), .Y_xor(yx1), .Y_not(yn1),
        .vec_idx(idx1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    gate_exerciser #(.HOLD_CYCLES(H2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
        .Y_and(ya2), .Y_or(yo2), .Y_xor(yx2), .Y_not(yn2),
        .vec_idx(idx2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_mask(mask2)
    );

    task automatic set_modes1(input int m0, input int m1, input int m2, input int m3);
        mode1[0] = m0; mode1[1] = m1; mode1[2] = m2; mode1[3] = m3;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        set_modes1(0, 0, 0, 0);
        for (int g = 0; g < 4; g++) mode2[g] = 0;
        repeat (3) @(negedge clk);
        got = {a1, b1, idx1, busy1, done1, pass1, err1, mask1[2:0]};
        checks++;
        if (got !== 14'd0 || mask1 !== 4'd0) begin
            failures++;
            $display("FAIL reset_dut1: got a,b,idx,busy,done,pass,err=%b mask=%b required all zero", got, mask1);
        end
        checks++;
        if ({a2, b2, idx2, busy2, done2, pass2, err2, mask2} !== 15'd0) begin
            failures++;
            $display("FAIL reset_dut2: got %b required all zero", {a2, b2, idx2, busy2, done2, pass2, err2, mask2});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full run on dut: expectations are counted straight from the truth table versus the injected faults.
    task automatic test_run(input string name, input bit glitch);
        int          exp_err;
        logic [3:0]  exp_mask;
        logic [5:0]  exp_ctl;
        int          vec;
        exp_err  = 0;
        exp_mask = 4'd0;
        for (int v = 0; v < 4; v++) begin
            for (int g = 0; g < 4; g++) begin
                if (obs(g, mode1[g], 1'((v >> 1) & 1), 1'(v & 1)) !== truth(g, 1'((v >> 1) & 1), 1'(v & 1))) begin
                    exp_err++;
                    exp_mask[g] = 1'b1;
                end
            end
        end
        if (exp_err > 16) exp_err = 16;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 * H1; k++) begin
            vec     = k / H1;
            exp_ctl = {1'b1, 1'b0, 2'(vec), 1'((vec >> 1) & 1), 1'(vec & 1)};
            checks++;
            if ({busy1, done1, idx1, a1, b1} !== exp_ctl) begin
                failures++;
                $display("FAIL %s_seq cycle %0d: busy,done,idx,a,b=%b required %b", name, k, {busy1, done1, idx1, a1, b1}, exp_ctl);
            end
            start = glitch && (k == 5 || k == 20);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if ({busy1, done1, idx1, a1, b1} !== 6'b010000) begin
            failures++;
            $display("FAIL %s_done: busy,done,idx,a,b=%b required 010000", name, {busy1, done1, idx1, a1, b1});
        end
        checks++;
        if (err1 !== 5'(exp_err) || mask1 !== exp_mask || pass1 !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s_result: err=%0d mask=%b pass=%b required err=%0d mask=%b pass=%b",
                     name, err1, mask1, pass1, exp_err, exp_mask, (exp_err == 0));
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || err1 !== 5'(exp_err) || mask1 !== exp_mask || pass1 !== (exp_err == 0)) begin
            failures++;
            $display("FAIL %s_hold: busy=%b done=%b err=%0d mask=%b pass=%b required 0 0 %0d %b %b",
                     name, busy1, done1, err1, mask1, pass1, exp_err, exp_mask, (exp_err == 0));
        end
    endtask

    task automatic test_midrun_reset();
        int  budget;
        bit  seen;
        set_modes1(0, 1, 0, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (budget = 0; budget < 200 && !seen; budget++) begin
            if (idx1 == 2'd2) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrun_wait: vec_idx never reached 2 (idx=%0d)", idx1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy1, done1, a1, b1, idx1, pass1, err1, mask1} !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy,done,a,b,idx,pass,err,mask=%b required all zero",
                     {busy1, done1, a1, b1, idx1, pass1, err1, mask1});
        end
        set_modes1(0, 0, 0, 0);
        test_run("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        int  budget;
        mode2[0] = 0; mode2[1] = 1; mode2[2] = 0; mode2[3] = 0;
        @(negedge clk);
        start2 = 1'b1;
        budget = 0;
        while (busy2 !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (busy2 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_start: busy=%b required 1", busy2);
        end
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4 * H2; k++) begin
                checks++;
                if (busy2 !== 1'b1 || done2 !== 1'b0 || idx2 !== 2'(k / H2)) begin
                    failures++;
                    $display("FAIL b2b_run%0d cycle %0d: busy=%b done=%b idx=%0d required 1 0 %0d", r, k, busy2, done2, idx2, k / H2);
                end
                if (k == 0) begin
                    checks++;
                    if (err2 !== 5'd0) begin
                        failures++;
                        $display("FAIL b2b_clear%0d: err=%0d required 0", r, err2);
                    end
                end
                @(negedge clk);
            end
            checks++;
            if (busy2 !== 1'b0 || done2 !== 1'b1 || err2 !== 5'd3 || mask2 !== 4'b0010 || pass2 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_done%0d: busy=%b done=%b err=%0d mask=%b pass=%b required 0 1 3 0010 0",
                         r, busy2, done2, err2, mask2, pass2);
            end
            @(negedge clk);
            checks++;
            if (busy2 !== 1'b0 || done2 !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle%0d: busy=%b done=%b required 0 0", r, busy2, done2);
            end
            @(negedge clk);
        end
        start2 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        set_modes1(0, 0, 0, 0);
        test_run("all_good", 1'b0);
        set_modes1(0, 1, 0, 0);
        test_run("or_stuck0", 1'b0);
        set_modes1(0, 0, 3, 4);
        test_run("xnor_notA", 1'b0);
        set_modes1(3, 3, 3, 3);
        test_run("all_inverted", 1'b0);
        set_modes1(0, 0, 0, 0);
        test_run("start_glitch", 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_modes1(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            test_run("random", 1'($urandom_range(0, 1)));
        end
        test_midrun_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
